// File: rtl/ucc_1bit_pkg.sv
// ucc_1bit shared types: counter-cell mode encoding.
// Used by ucc_next and ucc_1bit.
package ucc_1bit_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    LOAD = 2'd3
  } mode_t;

endpackage

// File: rtl/ucc_next.sv
// ucc_next: combinational next-bit and carry/borrow for one cell.
// In: cin, fin, pin, m[1:0]. Out: nxt, cout.
module ucc_next
  import ucc_1bit_pkg::*;
(
  input  logic       cin,
  input  logic       fin,
  input  logic       pin,
  input  logic [1:0] m,
  output logic       nxt,
  output logic       cout
);

  mode_t md;

  assign md = mode_t'(m);

  always_comb begin
    nxt  = fin;
    cout = 1'b0;
    unique case (md)
      HOLD: begin
        nxt  = fin;
        cout = 1'b0;
      end
      UP: begin
        nxt  = fin ^ cin;
        cout = fin & cin;
      end
      // borrow when the bit is 0 and we must take 1 from it
      DOWN: begin
        nxt  = fin ^ cin;
        cout = ~fin & cin;
      end
      LOAD: begin
        nxt  = pin;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ucc_1bit.sv
// ucc_1bit: one chainable up/down/load counter bit.
// In: clk, rst, cin, fin, pin, m. Out: cout, fout (reg), mo.
module ucc_1bit
  import ucc_1bit_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cin,
  input  logic       fin,
  input  logic       pin,
  input  logic [1:0] m,
  output logic       cout,
  output logic       fout,
  output logic [1:0] mo
);

  logic nxt;

  ucc_next u_next (
    .cin  (cin),
    .fin  (fin),
    .pin  (pin),
    .m    (m),
    .nxt  (nxt),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) fout <= RESET_VAL;
    else     fout <= nxt;
  end

  // mode ripples to the next cell untouched, reset included
  assign mo = m;

endmodule

// File: tb/tb_ucc_1bit.sv
// tb_ucc_1bit: vector table, toggle sequence and random
// stimulus against an arithmetic counter-bit model.
module tb_ucc_1bit;

  logic       clk;
  logic       rst;
  logic       cin;
  logic       fin;
  logic       pin;
  logic [1:0] m;
  logic       cout0, cout1;
  logic       fout0, fout1;
  logic [1:0] mo0, mo1;

  int checks;
  int errors;

  ucc_1bit #(.RESET_VAL(1'b0)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .cin  (cin),
    .fin  (fin),
    .pin  (pin),
    .m    (m),
    .cout (cout0),
    .fout (fout0),
    .mo   (mo0)
  );

  ucc_1bit #(.RESET_VAL(1'b1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .cin  (cin),
    .fin  (fin),
    .pin  (pin),
    .m    (m),
    .cout (cout1),
    .fout (fout1),
    .mo   (mo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cin;
    logic       fin;
    logic       pin;
    logic [1:0] m;
    logic       f0;
    logic       f1;
    logic       co;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm,
                     input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  // Reference: bit value plus/minus the incoming carry,
  // done in integers; low bit is the new value, overflow
  // or underflow is the outgoing carry/borrow.
  function automatic void model(input logic c,
                                input logic f,
                                input logic p,
                                input logic [1:0] md,
                                output logic n,
                                output logic co);
    int v;
    n  = f;
    co = 1'b0;
    if (md == 2'd1) begin
      v  = int'(f) + int'(c);
      n  = (v % 2) == 1;
      co = v >= 2;
    end else if (md == 2'd2) begin
      v  = int'(f) - int'(c);
      n  = ((v + 2) % 2) == 1;
      co = v < 0;
    end else if (md == 2'd3) begin
      n = p;
    end
  endfunction

  task automatic drive(input logic r, input logic c,
                       input logic f, input logic p,
                       input logic [1:0] md);
    rst = r;
    cin = c;
    fin = f;
    pin = p;
    m   = md;
  endtask

  initial begin
    logic n, co, e0, e1;
    logic [1:0] tmp;
    checks = 0;
    errors = 0;

    //       rst  cin  fin  pin  m     f0   f1   co
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b1,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,2'd0,1'b1,1'b1,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,2'd1,1'b1,1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,2'd1,1'b0,1'b0,1'b1};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b1,2'd2,1'b1,1'b1,1'b1};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b1,2'd2,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,2'd3,1'b1,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,2'd3,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b1,2'd3,1'b1,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,2'd1,1'b1,1'b1,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,2'd2,1'b1,1'b1,1'b0};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b1,2'd3,1'b0,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b1,2'd3,1'b1,1'b1,1'b0};
    tbl[14] = '{1'b1,1'b1,1'b1,1'b0,2'd1,1'b0,1'b1,1'b1};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b0,2'd1,1'b1,1'b1,1'b0};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].cin, tbl[i].fin,
            tbl[i].pin, tbl[i].m);
      #1;
      chk($sformatf("tbl%0d_cout", i),
          {1'b0, cout0}, {1'b0, tbl[i].co});
      chk($sformatf("tbl%0d_mo", i), mo0, tbl[i].m);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_fout0", i),
          {1'b0, fout0}, {1'b0, tbl[i].f0});
      chk($sformatf("tbl%0d_fout1", i),
          {1'b0, fout1}, {1'b0, tbl[i].f1});
    end

    // self-fed toggle: fin follows fout, counts 1,0,1,0
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, fout0, 1'b0, 2'd1);
      #1;
      chk($sformatf("tog%0d_cout", k),
          {1'b0, cout0}, {1'b0, ((k - 1) % 2) == 1});
      @(posedge clk);
      #1;
      chk($sformatf("tog%0d_fout", k),
          {1'b0, fout0}, {1'b0, (k % 2) == 1});
    end

    // random, with occasional reset mid-stream
    for (int k = 0; k < 300; k++) begin
      tmp = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom), 1'($urandom), tmp);
      #1;
      model(cin, fin, pin, m, n, co);
      chk("rnd_cout0", {1'b0, cout0}, {1'b0, co});
      chk("rnd_cout1", {1'b0, cout1}, {1'b0, co});
      chk("rnd_mo0", mo0, tmp);
      chk("rnd_mo1", mo1, tmp);
      e0 = rst ? 1'b0 : n;
      e1 = rst ? 1'b1 : n;
      @(posedge clk);
      #1;
      chk("rnd_fout0", {1'b0, fout0}, {1'b0, e0});
      chk("rnd_fout1", {1'b0, fout1}, {1'b0, e1});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ucc_1bit.md
UCC_1BIT -- requirements
Module: ucc_1bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock and reset are listed first.
REQ-002 Parameter RESET_VAL, default 1'b0, is the value loaded into the state bit on reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cin  input  1  carry/borrow-in from the lower-order cell; 1 = count this bit.
REQ-006 fin  input  1  current value of this bit, fed back from the counter chain.
REQ-007 pin  input  1  parallel-load data bit.
REQ-008 m  input  2  mode select: 0 hold, 1 count up, 2 count down, 3 parallel load.
REQ-009 cout  output  1  carry/borrow-out to the higher-order cell, combinational.
REQ-010 fout  output  1  registered next value of this bit.
REQ-011 mo  output  2  mode forwarded to the next cell, combinational copy of m.

Function
REQ-012 Next value nxt SHALL be computed combinationally:
- m=0: nxt=fin
- m=1: nxt=fin XOR cin
- m=2: nxt=fin XOR cin
- m=3: nxt=pin
REQ-013 cout SHALL be:
- m=0: 0
- m=1: fin AND cin (carry)
- m=2: (NOT fin) AND cin (borrow)
- m=3: 0
REQ-014 On each rising clk edge with rst=0, fout SHALL take nxt; latency is exactly one cycle from input change to fout.
REQ-015 cout and mo SHALL depend only on current inputs, with zero cycle latency, so cells can be ripple-chained within one cycle.
REQ-016 With cin=0, modes 1 and 2 SHALL leave the bit unchanged (nxt=fin) and drive cout=0.
REQ-017 In mode 3, pin SHALL have priority over fin and cin; in modes 0–2, pin SHALL be ignored.
REQ-018 mo SHALL equal m in every mode, including during reset.
REQ-019 No X-propagation SHALL be introduced: every 2-bit m value is defined, and no latch is inferred.

Reset
REQ-020 When rst=1 at a rising clk edge, fout SHALL become RESET_VAL regardless of the other inputs.
REQ-021 Reset SHALL not gate cout or mo; they remain combinational functions of the inputs.
REQ-022 If reset is asserted mid-operation, the pending nxt SHALL be discarded; normal updates resume on the first edge with rst=0.
REQ-023 Before the first clock edge, fout is undefined; the bench SHALL apply reset for at least one edge.

Structure
REQ-024 A shared package SHALL define the mode constants HOLD=2'd0, UP=2'd1, DOWN=2'd2, LOAD=2'd3, and the mode typedef.
REQ-025 One combinational sub-module, ucc_next, SHALL compute nxt and cout; the top level adds only the fout register and the mo pass-through.
REQ-026 Multi-bit counters are built by chaining cells, cout to the cin of the next cell and mo to the m of the next cell; that chaining is outside this block.

Verification
REQ-027 Hold: cin=1, m=0, fin=0 then 1 -> cout=0; fout=0 then 1 after one edge.
REQ-028 Up: cin=1, m=1, fin=0 -> fout=1, cout=0; fin=1 -> fout=0, cout=1.
REQ-029 Down: cin=1, m=2, fin=0 -> fout=1, cout=1; fin=1 -> fout=0, cout=0.
REQ-030 Load: m=3, fin=1, pin=1 -> fout=1, cout=0; pin=0 -> fout=0.
REQ-031 No carry: cin=0, fin=1, m=1 then m=2 -> fout=1, cout=0 in both modes; mo tracks m every cycle.
REQ-032 Reset: rst=1 with m=3, pin=1 -> fout=RESET_VAL at the next edge; release rst -> fout=1 one edge later.
